pipereg_chain: RTL

- Parametrised chain of pipeline registers. Replaces the hand-written per-boundary registers (fetch/decode, decode/execute, execute/memory, memory/writeback) with one block.
- Per-stage valid bits, valid/ready backpressure, per-stage stall (hazard interlock with bubble insertion) and per-stage flush (branch/jump squash).
- Sits between stage logic and the hazard unit. Also exports occupancy and flush statistics.

---
 rtl/pipereg_chain.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipereg_chain.sv
// Parametrised chain of pipeline registers with valid/ready backpressure, per-stage
// stall (bubble insertion) and flush (squash), plus occupancy and flush statistics.
module pipereg_chain #(
  parameter  int DATA_W = 32,
  parameter  int STAGES = 5,
  parameter  int CNT_W  = 16,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic [STAGES-1:0] stall_i,
  input  logic [STAGES-1:0] flush_i,
  output logic [STAGES-1:0] stage_valid_o,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // Headroom above CNT_W so a multi-stage flush cannot wrap before saturation.
  localparam int SUM_W = CNT_W + 4;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [DATA_W-1:0] d_q [STAGES];
  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] load;
  logic [OCC_W-1:0]  occ_d;
  logic [SUM_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_d;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    logic r;
    ready   = '0;
    vin     = '0;
    v_d     = '0;
    load    = '0;
    occ_d   = '0;
    cnt_sum = '0;
    cnt_d   = '0;

    // Ready walks back from the consumer through a local, so the vector never
    // feeds itself.
    r = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r        = ~stall_i[k] & (~v_q[k] | r);
      ready[k] = r;
    end

    vin[0] = in_valid_i;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = v_q[k-1] & ~stall_i[k-1] & ~flush_i[k-1];
    end

    // A loading stage takes whatever arrives (a bubble included); a holding stage
    // can still lose its item to flush.
    for (int k = 0; k < STAGES; k++) begin
      v_d[k]  = ready[k] ? vin[k] : (v_q[k] & ~flush_i[k]);
      load[k] = ready[k] & vin[k];
    end

    occ_d   = OCC_W'($countones(v_d));
    cnt_sum = SUM_W'(flush_cnt_o) + SUM_W'($countones(flush_i & v_q));
    cnt_d   = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      v_q         <= '0;
      occupancy_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      v_q         <= v_d;
      occupancy_o <= occ_d;
      flush_cnt_o <= cnt_d;
    end
  end

  // NOTE: payload registers are reset too, so out_data_o is a defined zero after
  // reset instead of stale or unknown contents.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
    end else begin
      if (load[0]) d_q[0] <= in_data_i;
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) d_q[k] <= d_q[k-1];
      end
    end
  end

  assign in_ready_o    = ready[0];
  assign out_valid_o   = v_q[STAGES-1] & ~stall_i[STAGES-1];
  assign out_data_o    = d_q[STAGES-1];
  assign stage_valid_o = v_q;

endmodule
